lsu_scheduler: RTL
==================

LSU_SCHEDULER -- requirements
Module: lsu_scheduler

Interface
REQ-001 SHALL have parameter LSU_COUNT, default 4, number of solving units scheduled.
REQ-002 SHALL have parameter JOB_WIDTH, default 224, width of one packed job (button count, buttons, joltages).
REQ-003 SHALL have parameter ANSWER_BIT_WIDTH, default 24, width of per-unit results and running total.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port job_valid  input  1  job buffer non-empty.
REQ-007 SHALL have port job_data  input  JOB_WIDTH  job at buffer top.
REQ-008 SHALL have port job_pop  output  1  one-cycle pop pulse to job buffer.
REQ-009 SHALL have port lsu_available  input  LSU_COUNT  per-unit idle flag.
REQ-010 SHALL have port lsu_start  output  LSU_COUNT  one-hot, one-cycle start pulse.
REQ-011 SHALL have port lsu_job_data  output  JOB_WIDTH  shared job bus to all units.
REQ-012 SHALL have port lsu_result_ready  input  LSU_COUNT  per-unit result-valid pulse.
REQ-013 SHALL have port lsu_result  input  LSU_COUNT*ANSWER_BIT_WIDTH  flattened results, unit k at [k*W +: W].
REQ-014 SHALL have port send_valid  output  1  one-cycle pulse to byte sender.
REQ-015 SHALL have port send_data  output  ANSWER_BIT_WIDTH  running total after latest accumulate.
REQ-016 SHALL have port outstanding  output  $clog2(LSU_COUNT+1)  jobs dispatched, not yet accumulated.
REQ-017 SHALL have port error  output  1  sticky: result dropped or total overflowed.

Function
REQ-018 Dispatch FSM states SHALL be IDLE, ISSUE, HOLD.
REQ-019 Eligible unit k SHALL mean lsu_available[k]=1 and pending[k]=0.
REQ-020 In IDLE at cycle T with job_valid=1 and any eligible unit: grant round-robin, search starting at last_grant+1 mod LSU_COUNT; at T+1 job_pop=1, lsu_job_data=job_data, state ISSUE.
REQ-021 In ISSUE: lsu_start[grant]=1 for exactly one cycle (T+2); lsu_job_data unchanged; state HOLD; last_grant updated.
REQ-022 HOLD SHALL last 2 cycles (T+2,T+3), then IDLE at T+4; earliest next job_pop T+5.
REQ-023 lsu_job_data SHALL hold its value until next grant.
REQ-024 In IDLE with job_valid=0 or no eligible unit: no pulses, remain IDLE.
REQ-025 Result capture: lsu_result_ready[k]=1 at T SHALL set pending[k] and latch slot[k]=lsu_result[k] at T+1, including result value 0.
REQ-026 lsu_result_ready[k] while pending[k]=1 SHALL drop new value, keep old, set error.
REQ-027 Collector: each cycle, if any pending, pick one round-robin (independent pointer); next cycle total+=slot, send_valid=1, send_data=new total, pending cleared; max one accumulate per cycle.
REQ-028 Result pulse at T on empty collector SHALL yield send_valid at T+2.
REQ-029 Total SHALL wrap modulo 2^ANSWER_BIT_WIDTH; carry-out sets error.
REQ-030 outstanding +1 on job_pop, -1 on accumulate, unchanged when both in same cycle; never exceeds LSU_COUNT.
REQ-031 Capture into slot j and drain of slot k same cycle SHALL both take effect.
REQ-032 Multiple simultaneous lsu_result_ready bits SHALL all be captured same cycle.

Reset
REQ-033 reset=0 SHALL immediately clear: state IDLE, job_pop, lsu_start, send_valid, send_data, total, pending, outstanding, error, both round-robin pointers to LSU_COUNT-1, lsu_job_data to 0.
REQ-034 Reset mid-dispatch SHALL abort without start pulse; first action after release SHALL be no earlier than 1 cycle after deassertion.

Verification
REQ-035 Single job: job_valid=1, all available -> job_pop T+1, lsu_start=0001 T+2, result 7 -> send_valid send_data=7, outstanding 1->0.
REQ-036 Round-robin: 5 jobs, all units available, none finish -> starts 0001,0010,0100,1000, job_pop every 4 cycles, 5th stalls until unit frees.
REQ-037 Simultaneous results 3,5,9,0 on all units -> four send_valid pulses on consecutive cycles, totals 3,8,17,17.
REQ-038 Pending not drained, unit re-pulses result -> error=1, total unaffected by second value.
REQ-039 Total 0xFFFFF0 plus 0x20 -> send_data=0x000010, error=1.
REQ-040 reset low during ISSUE -> lsu_start stays 0, all outputs 0 asynchronously, normal dispatch after release.

Source files
------------

// File: rtl/lsu_scheduler.sv
// Dispatches jobs round-robin to a pool of solving units and folds their results
// into a running total that is streamed out to the byte sender.
module lsu_scheduler #(
    parameter int LSU_COUNT        = 4,
    parameter int JOB_WIDTH        = 224,
    parameter int ANSWER_BIT_WIDTH = 24
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  job_valid,
    input  logic [JOB_WIDTH-1:0]                  job_data,
    output logic                                  job_pop,
    input  logic [LSU_COUNT-1:0]                  lsu_available,
    output logic [LSU_COUNT-1:0]                  lsu_start,
    output logic [JOB_WIDTH-1:0]                  lsu_job_data,
    input  logic [LSU_COUNT-1:0]                  lsu_result_ready,
    input  logic [LSU_COUNT*ANSWER_BIT_WIDTH-1:0] lsu_result,
    output logic                                  send_valid,
    output logic [ANSWER_BIT_WIDTH-1:0]           send_data,
    output logic [$clog2(LSU_COUNT+1)-1:0]        outstanding,
    output logic                                  error
);

    localparam int W     = ANSWER_BIT_WIDTH;
    localparam int IDX_W = (LSU_COUNT > 1) ? $clog2(LSU_COUNT) : 1;
    localparam int OUT_W = $clog2(LSU_COUNT + 1);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(LSU_COUNT);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(LSU_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester after 'last', wrapping around; 'last' itself is checked last.
    function automatic pick_t rr_pick(input logic [LSU_COUNT-1:0] req,
                                      input logic [IDX_W-1:0]     last);
        pick_t res;
        int    idx;
        res = '0;
        for (int k = 1; k <= LSU_COUNT; k++) begin
            idx = int'(last) + k;
            if (idx >= LSU_COUNT) idx = idx - LSU_COUNT;
            if (!res.found && req[IDX_W'(idx)]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(idx);
            end
        end
        return res;
    endfunction

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_hold_cnt;
    logic                   r_job_pop;
    logic [LSU_COUNT-1:0]   r_start;
    logic [LSU_COUNT-1:0]   w_start_next;
    logic [JOB_WIDTH-1:0]   r_job_data;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last_grant;
    logic [OUT_W-1:0]       r_outstanding;
    logic [LSU_COUNT-1:0]   r_pending;
    logic [W-1:0]           r_slot [LSU_COUNT];
    logic [IDX_W-1:0]       r_last_drain;
    logic [W-1:0]           r_total;
    logic                   r_send_valid;
    logic [W-1:0]           r_send_data;
    logic                   r_error;

    logic [LSU_COUNT-1:0]   w_eligible;
    pick_t                  w_grant;
    pick_t                  w_drain;
    logic                   w_dispatch;
    logic [LSU_COUNT-1:0]   w_capture;
    logic [LSU_COUNT-1:0]   w_drop;
    logic [LSU_COUNT-1:0]   w_clear;
    logic [W:0]             w_sum;

    assign w_eligible = lsu_available & ~r_pending;
    assign w_grant    = rr_pick(w_eligible, r_last_grant);
    assign w_drain    = rr_pick(r_pending, r_last_drain);

    // A unit re-pulsing while its previous result is still pending loses the new value.
    assign w_capture  = lsu_result_ready & ~r_pending;
    assign w_drop     = lsu_result_ready & r_pending;
    assign w_sum      = {1'b0, r_total} + {1'b0, r_slot[w_drain.idx]};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_dispatch   = 1'b0;
        w_start_next = '0;
        w_clear      = '0;
        case (r_state)
            S_IDLE: begin
                if (job_valid && w_grant.found && (r_outstanding != OUT_MAX)) begin
                    w_dispatch   = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start_next[r_grant] = 1'b1;
                w_state_next          = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_drain.found) w_clear[w_drain.idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_hold_cnt   <= 1'b0;
            r_job_pop    <= 1'b0;
            r_start      <= '0;
            r_job_data   <= '0;
            r_grant      <= PTR_RESET;
            r_last_grant <= PTR_RESET;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= (r_state == S_HOLD) ? ~r_hold_cnt : 1'b0;
            r_job_pop  <= w_dispatch;
            r_start    <= w_start_next;
            if (w_dispatch) begin
                r_job_data <= job_data;
                r_grant    <= w_grant.idx;
            end
            if (r_state == S_ISSUE) r_last_grant <= r_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending     <= '0;
            r_last_drain  <= PTR_RESET;
            r_total       <= '0;
            r_send_valid  <= 1'b0;
            r_send_data   <= '0;
            r_error       <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_clear) | w_capture;
            r_send_valid <= w_drain.found;
            if (w_drain.found) begin
                r_total      <= w_sum[W-1:0];
                r_send_data  <= w_sum[W-1:0];
                r_last_drain <= w_drain.idx;
            end
            if ((|w_drop) || (w_drain.found && w_sum[W])) r_error <= 1'b1;
            case ({w_dispatch, w_drain.found})
                2'b10: if (r_outstanding != OUT_MAX) r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01: if (r_outstanding != '0)      r_outstanding <= r_outstanding - OUT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: result slots are storage gated by r_pending, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LSU_COUNT; k++) begin
            if (w_capture[k]) r_slot[k] <= lsu_result[k*W +: W];
        end
    end

    assign job_pop      = r_job_pop;
    assign lsu_start    = r_start;
    assign lsu_job_data = r_job_data;
    assign send_valid   = r_send_valid;
    assign send_data    = r_send_data;
    assign outstanding  = r_outstanding;
    assign error        = r_error;

endmodule
